// File: rtl/if_id_queue_pkg.sv
// Shared widths for the fetch-to-decode instruction queue.
// Mirrors WORD / INSTR_LEN from the system definitions and the default depth.
package if_id_queue_pkg;
    localparam int WORD      = 64;
    localparam int INSTR_LEN = 32;
    localparam int IFQ_DEPTH = 4;
    localparam int ENTRY_W   = INSTR_LEN + 2 * WORD;
endpackage

// File: rtl/ifq_mem.sv
// Queue storage: DEPTH x W register array, one write port, one async read port.
// Latency: write visible after the edge; read is combinational. No reset, no backpressure.
module ifq_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 128
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue with show-ahead head and branch flush.
// Latency: one cycle push-to-visible; full stalls fetch from registered count only.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_valid,
    input  logic [INSTR_LEN-1:0]       instruction,
    input  logic [WORD-1:0]            cur_pc,
    input  logic [WORD-1:0]            incremented_pc,
    input  logic                       flush,
    output logic                       fetch_stall,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [INSTR_LEN-1:0]       dec_instr,
    output logic [WORD-1:0]            dec_pc,
    output logic [WORD-1:0]            dec_inc_pc,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               full, empty, push, pop;
    logic [ENTRY_W-1:0] wdata, rdata;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // A push while full is refused even if a pop frees a slot in the same cycle.
    assign push  = fetch_valid && !full && !flush;
    assign pop   = !empty && dec_ready && !flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wdata = {instruction, cur_pc, incremented_pc};

    ifq_mem #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    assign fetch_stall = full;
    assign dec_valid   = !empty;
    assign count       = count_q;
    assign dec_instr   = empty ? '0 : rdata[ENTRY_W-1 -: INSTR_LEN];
    assign dec_pc      = empty ? '0 : rdata[2*WORD-1 -: WORD];
    assign dec_inc_pc  = empty ? '0 : rdata[WORD-1:0];
endmodule
